// File: rtl/text_line_pkg.sv
// Shared definitions for the text line renderer.
// Contents: character code constants, glyph geometry, line FSM state type,
// and the glyph table used by every text renderer (one 64-bit word per code,
// row 0 in the top byte, bit 7 of each row = leftmost pixel).
package text_line_pkg;

    localparam int CODE_W  = 5;
    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 8;

    localparam logic [4:0] CH_A = 5'd0,  CH_B = 5'd1,  CH_C = 5'd2,  CH_D = 5'd3;
    localparam logic [4:0] CH_E = 5'd4,  CH_F = 5'd5,  CH_G = 5'd6,  CH_H = 5'd7;
    localparam logic [4:0] CH_I = 5'd8,  CH_J = 5'd9,  CH_K = 5'd10, CH_L = 5'd11;
    localparam logic [4:0] CH_M = 5'd12, CH_N = 5'd13, CH_O = 5'd14, CH_P = 5'd15;
    localparam logic [4:0] CH_Q = 5'd16, CH_R = 5'd17, CH_S = 5'd18, CH_T = 5'd19;
    localparam logic [4:0] CH_U = 5'd20, CH_V = 5'd21, CH_W = 5'd22, CH_X = 5'd23;
    localparam logic [4:0] CH_Y = 5'd24, CH_Z = 5'd25;
    localparam logic [4:0] CH_SPACE = 5'd26, CH_ONE = 5'd27, CH_TWO = 5'd28, CH_COLON = 5'd29;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } line_state_t;

    // Codes 30-31 and space fall through to an all-zero glyph.
    function automatic logic [63:0] glyph_bits(input logic [4:0] code);
        case (code)
            CH_A:     glyph_bits = 64'h18244242_7E424200;
            CH_B:     glyph_bits = 64'h7C42427C_42427C00;
            CH_C:     glyph_bits = 64'h3C424040_40423C00;
            CH_D:     glyph_bits = 64'h78444242_42447800;
            CH_E:     glyph_bits = 64'h7E40407C_40407E00;
            CH_F:     glyph_bits = 64'h7E40407C_40404000;
            CH_G:     glyph_bits = 64'h3C42404E_42423C00;
            CH_H:     glyph_bits = 64'h4242427E_42424200;
            CH_I:     glyph_bits = 64'h3E080808_08083E00;
            CH_J:     glyph_bits = 64'h1E040404_44443800;
            CH_K:     glyph_bits = 64'h42444870_48444200;
            CH_L:     glyph_bits = 64'h40404040_40407E00;
            CH_M:     glyph_bits = 64'h42665A42_42424200;
            CH_N:     glyph_bits = 64'h4262524A_46424200;
            CH_O:     glyph_bits = 64'h3C424242_42423C00;
            CH_P:     glyph_bits = 64'h7C42427C_40404000;
            CH_Q:     glyph_bits = 64'h3C424242_4A443A00;
            CH_R:     glyph_bits = 64'h7C42427C_48444200;
            CH_S:     glyph_bits = 64'h3C42403C_02423C00;
            CH_T:     glyph_bits = 64'h7F080808_08080800;
            CH_U:     glyph_bits = 64'h42424242_42423C00;
            CH_V:     glyph_bits = 64'h42424242_24241800;
            CH_W:     glyph_bits = 64'h42424242_5A664200;
            CH_X:     glyph_bits = 64'h42241818_18244200;
            CH_Y:     glyph_bits = 64'h41221408_08080800;
            CH_Z:     glyph_bits = 64'h7E040810_20407E00;
            CH_ONE:   glyph_bits = 64'h08182808_08083E00;
            CH_TWO:   glyph_bits = 64'h3C42020C_30407E00;
            CH_COLON: glyph_bits = 64'h00181800_18180000;
            default:  glyph_bits = 64'h0;
        endcase
    endfunction

endpackage

// File: rtl/text_line_if.sv
// Character-write bus between game logic (master) and a text line (slave).
// Signals: clr (blank line, rewind pointer), wr_valid/wr_char/wr_ready
// (append handshake), busy (clear pass in progress).
interface text_line_if;
    logic                              clr;
    logic                              wr_valid;
    logic [text_line_pkg::CODE_W-1:0]  wr_char;
    logic                              wr_ready;
    logic                              busy;

    modport master (output clr, output wr_valid, output wr_char,
                    input  wr_ready, input busy);
    modport slave  (input  clr, input  wr_valid, input  wr_char,
                    output wr_ready, output busy);
endinterface

// File: rtl/text_line_glyph_rom.sv
// Registered glyph ROM: returns the 8-pixel row pattern of a character one
// clock after code/row are presented.
// Ports: clk; i_code[4:0] character code; i_row[2:0] glyph row (0 = top);
// o_pattern[7:0] row pixels, bit 7 = leftmost.
module text_line_glyph_rom
    import text_line_pkg::*;
(
    input  logic       clk,
    input  logic [4:0] i_code,
    input  logic [2:0] i_row,
    output logic [7:0] o_pattern
);
    logic [63:0] w_glyph;
    logic [7:0]  r_pattern;

    assign w_glyph = glyph_bits(i_code);

    // Row 0 sits in the top byte, so the byte offset is 8 * (7 - row).
    always_ff @(posedge clk) begin
        r_pattern <= w_glyph[{~i_row, 3'b000} +: 8];
    end

    assign o_pattern = r_pattern;
endmodule

// File: rtl/text_line.sv
// One line of NCHARS character cells placed at (XLOC, YLOC). Game logic
// appends codes through the write bus; the scan pipeline turns the current
// hcount/vcount into a 1-bit text pixel three clocks later.
// Ports: clk, rst (async, active high); wr_bus (text_line_if slave);
// i_pixpulse pixel strobe (hcount/vcount hold for 4 clk between strobes);
// i_hcount/i_vcount scan position; o_draw_text text pixel.
module text_line
    import text_line_pkg::*;
#(
    parameter int XLOC   = 40,
    parameter int YLOC   = 40,
    parameter int NCHARS = 16
) (
    input  logic        clk,
    input  logic        rst,
    text_line_if.slave  wr_bus,
    input  logic        i_pixpulse,
    input  logic [9:0]  i_hcount,
    input  logic [9:0]  i_vcount,
    output logic        o_draw_text
);
    localparam int          IDX_W  = $clog2(NCHARS);
    localparam logic [10:0] LINE_W = 11'(GLYPH_W * NCHARS);

    line_state_t              r_state, w_next_state;
    logic [IDX_W-1:0]         r_wr_ptr, r_clr_idx;
    logic                     w_wr_ready, w_accept;
    logic                     w_buf_we;
    logic [IDX_W-1:0]         w_buf_waddr;
    logic [CODE_W-1:0]        w_buf_wdata;
    logic [CODE_W-1:0]        r_buf [NCHARS];

    // The scan pipeline is free-running; the pixel strobe is not needed here.
    logic w_unused;
    assign w_unused = i_pixpulse;

    // ---------------- write / clear FSM ----------------
    // NOTE: every always_comb output gets a default first, so no path leaves a value held (no latch).
    always_comb begin
        w_next_state = r_state;
        w_wr_ready   = 1'b0;
        w_buf_we     = 1'b0;
        w_buf_waddr  = r_wr_ptr;
        w_buf_wdata  = wr_bus.wr_char;
        case (r_state)
            ST_IDLE: begin
                // clr has priority: a char offered in the same clk is refused.
                w_wr_ready = !wr_bus.clr;
                if (wr_bus.clr)
                    w_next_state = ST_CLEAR;
                else if (wr_bus.wr_valid)
                    w_buf_we = 1'b1;
            end
            ST_CLEAR: begin
                w_buf_we    = 1'b1;
                w_buf_waddr = r_clr_idx;
                w_buf_wdata = CH_SPACE;
                if (!wr_bus.clr && r_clr_idx == IDX_W'(NCHARS - 1))
                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_CLEAR;
        endcase
    end

    assign w_accept        = w_wr_ready & wr_bus.wr_valid;
    assign wr_bus.wr_ready = w_wr_ready;
    assign wr_bus.busy     = (r_state == ST_CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_wr_ptr  <= '0;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_next_state;
            if (wr_bus.clr) begin
                r_clr_idx <= '0;
                r_wr_ptr  <= '0;
            end else begin
                // NCHARS is a power of two, so both counters wrap to 0 on their own.
                if (r_state == ST_CLEAR)
                    r_clr_idx <= r_clr_idx + 1'b1;
                if (w_accept)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    // NOTE: the character array has no reset; it maps to distributed RAM and the CLEAR pass blanks it.
    always_ff @(posedge clk) begin
        if (w_buf_we)
            r_buf[w_buf_waddr] <= w_buf_wdata;
    end

    // ---------------- scan pipeline ----------------
    // 11-bit differences: a position left of/above the line wraps to a large
    // value and fails the range test instead of aliasing into the line.
    logic [10:0]       w_hdiff, w_vdiff;
    logic              w_in_box;
    logic [IDX_W-1:0]  w_idx;
    logic [7:0]        w_pattern;

    assign w_hdiff  = {1'b0, i_hcount} - 11'(XLOC);
    assign w_vdiff  = {1'b0, i_vcount} - 11'(YLOC);
    assign w_in_box = (w_hdiff < LINE_W) && (w_vdiff < 11'(GLYPH_H));
    assign w_idx    = w_hdiff[3 +: IDX_W];

    logic [CODE_W-1:0] r_s0_code;
    logic [2:0]        r_s0_col, r_s0_row, r_s1_col;
    logic              r_s0_in_box, r_s1_in_box, r_draw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_code   <= CH_SPACE;
            r_s0_col    <= '0;
            r_s0_row    <= '0;
            r_s0_in_box <= 1'b0;
            r_s1_col    <= '0;
            r_s1_in_box <= 1'b0;
            r_draw      <= 1'b0;
        end else begin
            r_s0_code   <= r_buf[w_idx];
            r_s0_col    <= w_hdiff[2:0];
            r_s0_row    <= w_vdiff[2:0];
            r_s0_in_box <= w_in_box;
            r_s1_col    <= r_s0_col;
            r_s1_in_box <= r_s0_in_box;
            r_draw      <= r_s1_in_box & w_pattern[3'd7 - r_s1_col];
        end
    end

    text_line_glyph_rom u_glyph_rom (
        .clk       (clk),
        .i_code    (r_s0_code),
        .i_row     (r_s0_row),
        .o_pattern (w_pattern)
    );

    assign o_draw_text = r_draw;
endmodule

// File: tb/tb_text_line.sv
// Directed bench for text_line: reset/clear length, handshake, wrap of the
// write pointer, clr priority, scan boundaries and reset during a clear.
module tb_text_line;
    import text_line_pkg::*;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       pixpulse = 1'b0;
    logic [9:0] hcount   = '0;
    logic [9:0] vcount   = '0;
    logic       draw_text;
    int         n_checks = 0;
    int         n_errors = 0;
    int         pcnt     = 0;

    text_line_if bus ();

    text_line #(.XLOC(40), .YLOC(40), .NCHARS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_bus      (bus),
        .i_pixpulse  (pixpulse),
        .i_hcount    (hcount),
        .i_vcount    (vcount),
        .o_draw_text (draw_text)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        pcnt     = (pcnt + 1) % 4;
        pixpulse = (pcnt == 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts rising edges until busy drops (bounded).
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic write_char(input logic [4:0] code);
        int t;
        t = 0;
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_char  = code;
        while (!bus.wr_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("wr_timeout", t, 0);
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
    endtask

    task automatic do_clear(output int cycles);
        @(negedge clk);
        bus.clr = 1'b1;
        @(posedge clk);
        #1;
        bus.clr = 1'b0;
        wait_idle(cycles);
    endtask

    // Presents one position and samples draw_text three clocks later.
    task automatic pix(input int h, input int v, output logic d);
        @(negedge clk);
        hcount = 10'(h);
        vcount = 10'(v);
        repeat (3) @(posedge clk);
        #1;
        d = draw_text;
    endtask

    initial begin
        int          cyc;
        int          ones;
        logic        d;
        logic [7:0]  h_row3;

        bus.clr      = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_char  = '0;
        h_row3       = 8'h7E;

        // ---- 1. reset state, clear length, blank line ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 1);
        check("rst_wr_ready", bus.wr_ready, 0);
        check("rst_draw", draw_text, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_idle(cyc);
        check("init_clear_len", cyc, 16);
        check("idle_wr_ready", bus.wr_ready, 1);
        ones = 0;
        for (int v = 40; v <= 47; v++)
            for (int h = 40; h <= 167; h++) begin
                pix(h, v, d);
                if (d) ones++;
            end
        check("blank_line_ones", ones, 0);

        // ---- 2. "HAME", row 3 of H ----
        write_char(CH_H);
        write_char(CH_A);
        write_char(CH_M);
        write_char(CH_E);
        for (int i = 0; i < 8; i++) begin
            pix(40 + i, 43, d);
            check($sformatf("h_row3_col%0d", i), d, h_row3[7 - i]);
        end
        // latency: going from col0 (0) to col1 (1) shows only after 3 clk
        @(negedge clk);
        hcount = 10'd41;
        repeat (2) @(posedge clk);
        #1;
        check("latency_2clk", draw_text, 0);
        @(posedge clk);
        #1;
        check("latency_3clk", draw_text, 1);

        // ---- 3. 17 writes wrap the pointer ----
        do_clear(cyc);
        check("clr_len_t3", cyc, 16);
        for (int i = 0; i < 16; i++) write_char(CH_H);
        write_char(CH_SPACE);
        pix(41, 43, d);  check("wrap_cell0_blank", d, 0);
        pix(49, 43, d);  check("wrap_cell1_kept", d, 1);
        pix(161, 43, d); check("wrap_cell15_kept", d, 1);
        write_char(CH_SPACE);
        pix(49, 43, d);  check("ptr1_cell1_blank", d, 0);
        pix(57, 43, d);  check("ptr1_cell2_kept", d, 1);

        // ---- 4. clr and wr_valid in the same clk ----
        @(negedge clk);
        bus.clr      = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_char  = CH_H;
        #1;
        check("clr_prio_ready", bus.wr_ready, 0);
        @(posedge clk);
        #1;
        bus.clr = 1'b0;
        check("clr_busy", bus.busy, 1);
        wait_idle(cyc);
        check("clr_len_t4", cyc, 16);
        check("held_valid_ready", bus.wr_ready, 1);
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        pix(41, 43, d);  check("held_to_idx0", d, 1);
        pix(49, 43, d);  check("idx1_cleared", d, 0);
        write_char(CH_H);
        pix(49, 43, d);  check("next_to_idx1", d, 1);

        // ---- 5. boundaries ----
        do_clear(cyc);
        for (int i = 0; i < 16; i++) write_char(CH_H);
        pix(41, 43, d);  check("in_left", d, 1);
        pix(161, 43, d); check("in_right_cell15", d, 1);
        pix(39, 43, d);  check("out_h39", d, 0);
        pix(168, 43, d); check("out_h168", d, 0);
        pix(41, 40, d);  check("in_top_row0", d, 1);
        pix(41, 39, d);  check("out_v39", d, 0);
        pix(41, 48, d);  check("out_v48", d, 0);
        write_char(5'd31);
        pix(41, 43, d);  check("code31_blank", d, 0);
        pix(49, 43, d);  check("code31_neighbor", d, 1);

        // reset in the middle of a clear (clr_idx = 5)
        @(negedge clk);
        bus.clr = 1'b1;
        @(posedge clk);
        #1;
        bus.clr = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midclr_rst_busy", bus.busy, 1);
        check("midclr_rst_ready", bus.wr_ready, 0);
        check("midclr_rst_draw", draw_text, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_idle(cyc);
        check("midclr_restart_len", cyc, 16);
        pix(121, 43, d); check("midclr_cell10_blank", d, 0);
        write_char(CH_H);
        pix(41, 43, d);  check("midclr_ptr0", d, 1);
        pix(49, 43, d);  check("midclr_cell1_blank", d, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
